seq_onehot_decoder: RTL and testbench
=====================================

// Module: seq_onehot_decoder
// PURPOSE
//  Registered, parametrised binary-to-one-hot decoder with a valid/ready input handshake.
//  Each decoded output is held for a programmable number of cycles, then cleared.
//  Codes outside the output range raise an error pulse instead of selecting an output.
//  Drives select/strobe lines, e.g. bank enables, from a control FSM.
// PARAMETERS
//  IN_W      3   width of binary select code
//  NUM_OUT   8   number of one-hot outputs; legal range 2..2**IN_W
//  HOLD_CYC  1   cycles each decoded output stays asserted; >=1
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, asynchronous, active-high
//  in_valid    in   1        in_sel is valid this cycle
//  in_ready    out  1        block can accept a code this cycle
//  in_sel      in   IN_W     binary select code
//  out_onehot  out  NUM_OUT  registered one-hot output; all-zero when idle
//  out_valid   out  1        high while out_onehot is non-zero
//  err         out  1        1-cycle pulse: accepted in_sel >= NUM_OUT
//  scan_req    in   1        [DEC_SCAN_EN only] request an auto-scan
//  scan_done   out  1        [DEC_SCAN_EN only] 1-cycle pulse at end of scan
// BEHAVIOUR
//  - Reset, async on rst: state=IDLE; out_onehot=0, out_valid=0, err=0, scan_done=0, hold count=0.
//  - in_ready is 0 while rst is high.
//  - Accept: in_valid && in_ready at a rising edge.
//  - FSM IDLE: in_ready=1.
//    - Accept with sel<NUM_OUT -> HOLD. Next cycle: out_onehot=1<<sel, out_valid=1, cnt=HOLD_CYC-1.
//    - Accept with sel>=NUM_OUT -> stay IDLE. Next cycle: err=1 for 1 cycle; out_onehot stays 0.
//  - FSM HOLD: cnt decrements each cycle; in_ready=(cnt==0).
//    - cnt==0, no accept -> IDLE. Next cycle: out_onehot=0, out_valid=0.
//    - cnt==0 with legal accept -> new code drives out_onehot next cycle, no gap cycle.
//    - cnt==0 with illegal accept -> outputs clear as for IDLE; err pulses.
//  - Latency: accept edge to out_onehot = 1 cycle.
//  - Each code is asserted for exactly HOLD_CYC cycles.
//  - in_sel is sampled only at accept; later changes are ignored.
//  - Invariant: out_onehot has at most one bit set; out_valid == |out_onehot.
//  - cnt width = clog2(HOLD_CYC) (min 1 bit). cnt never wraps; it reloads only on accept.
//  - rst mid-HOLD: outputs clear immediately (async); the in-flight code is discarded.
// CONFIGURATION
//  Macro DEC_SCAN_EN.
//  - Defined: adds ports scan_req/scan_done and FSM state SCAN.
//    - IDLE with scan_req=1 and no accept -> SCAN. A same-cycle in_valid has priority over scan_req.
//    - In SCAN: in_ready=0; outputs index 0,1,..,NUM_OUT-1, each for HOLD_CYC cycles.
//    - After the last index: scan_done pulses 1 cycle, together with out_onehot clearing; -> IDLE.
//    - scan_req is level-sensitive. If still high at return to IDLE, the scan restarts after 1 idle cycle.
//  - Undefined: no scan ports, no SCAN state. Behaviour is exactly as above.
// STRUCTURE
//  - Package dec_pkg holds:
//    - typedef dec_state_e {IDLE, HOLD, SCAN}; SCAN is encoded even when unused.
//    - function clog2_min1(int) for counter widths.
//    - localparam checks NUM_OUT<=2**IN_W and HOLD_CYC>=1, failing elaboration otherwise.
//  - One sub-module, dec_hold_cnt: loadable down-counter with a zero flag.
//    - Ports: clk, rst, load, load_val, zero.
//    - Shared by the HOLD and SCAN paths.
// TESTING  (IN_W=3, NUM_OUT=6, HOLD_CYC=3 unless noted)
//  1 Reset: rst=1 mid-HOLD with out_onehot=6'b000100 -> same cycle out_onehot=0, out_valid=0, in_ready=0.
//    After release: in_ready=1.
//  2 Single decode: accept sel=3 at edge T -> out_onehot=6'b001000 for T+1..T+3; 0 at T+4.
//    in_ready=0 at T+1,T+2; in_ready=1 at T+3.
//  3 Back-to-back: sel=1 accepted at T, sel=5 held valid from T+1 -> accepted at T+3.
//    Output 000010 for T+1..T+3, then 100000 for T+4..T+6; no zero gap.
//  4 Out of range: accept sel=7 -> err=1 at the next cycle only; out_onehot stays 0; in_ready stays 1.
//  5 HOLD_CYC=1: in_valid constant high, sel sequence 0,1,2 -> one-hot 1,2,4 on consecutive cycles.
//    in_ready stays 1 throughout.
//  6 DEC_SCAN_EN: pulse scan_req -> one-hot 1,2,4,8,16,32, each for 3 cycles (18 cycles total).
//    scan_done pulses once as out_onehot clears to 0; in_ready=0 throughout the scan.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and elaboration helpers for the one-hot decoder.
// SCAN is always part of the state encoding. Only builds with DEC_SCAN_EN can reach it.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } dec_state_e;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w = w + 1;
        return (w < 1) ? 1 : w;
    endfunction

    // Legal parameter combination: 2 <= num_out <= 2**in_w and hold_cyc >= 1.
    function automatic bit params_ok(input int in_w, input int num_out, input int hold_cyc);
        return (num_out >= 2) && (num_out <= (1 << in_w)) && (hold_cyc >= 1);
    endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Loadable down-counter with a zero flag. It times how long each decoded output is held.
// Once it reaches zero it stays there until the next load.
module dec_hold_cnt
    import dec_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and stop at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered binary-to-one-hot decoder with a valid/ready input and a programmable hold time.
// Codes at or above NUM_OUT do not select an output. They raise a 1-cycle err pulse instead.
// Optional feature macro: DEC_SCAN_EN adds scan_req/scan_done and an auto-scan of all outputs.
//
// Handshake: a code is accepted on a rising clk edge when in_valid && in_ready.
// in_ready depends only on the state and is never derived from in_valid.
// in_sel is sampled only at the accept edge.
module seq_onehot_decoder
    import dec_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int NUM_OUT  = 8,
    parameter int HOLD_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_sel,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic               out_valid,
    output logic               err,
`ifdef DEC_SCAN_EN
    input  logic               scan_req,
    output logic               scan_done,
`endif
    output dec_state_e         dbg_state
);

    localparam int CW = clog2_min1(HOLD_CYC);
    localparam logic [CW-1:0]      RELOAD    = CW'(HOLD_CYC - 1);
    localparam logic [IN_W:0]      NUM_OUT_C = (IN_W + 1)'(NUM_OUT);
    localparam logic [NUM_OUT-1:0] ONE       = NUM_OUT'(1);

    if (!params_ok(IN_W, NUM_OUT, HOLD_CYC)) begin : g_param_err
        $error("seq_onehot_decoder: illegal IN_W/NUM_OUT/HOLD_CYC combination");
    end

    dec_state_e        state;
    logic              accept;
    logic              legal;
    logic              zero;
    logic              load;
    logic [NUM_OUT-1:0] sel_onehot;

`ifdef DEC_SCAN_EN
    localparam logic [IN_W-1:0] LAST = IN_W'(NUM_OUT - 1);
    logic [IN_W-1:0] idx;
    logic            scan_start;
    logic            scan_step;
    assign scan_start = (state == IDLE) && !in_valid && scan_req;
    assign scan_step  = (state == SCAN) && zero && (idx != LAST);
`endif

    // in_ready is held low during reset and while a code or a scan step is still being held.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                HOLD:    in_ready = zero;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept     = in_valid && in_ready;
    assign legal      = ({1'b0, in_sel} < NUM_OUT_C);
    assign sel_onehot = ONE << in_sel;

    // The hold timer restarts whenever a new output pattern is loaded.
`ifdef DEC_SCAN_EN
    assign load = (accept && legal) || scan_start || scan_step;
`else
    assign load = accept && legal;
`endif

    dec_hold_cnt #(.W(CW)) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (RELOAD),
        .zero     (zero)
    );

    // Control FSM with registered one-hot, err and scan_done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_onehot <= '0;
            err        <= 1'b0;
`ifdef DEC_SCAN_EN
            scan_done  <= 1'b0;
            idx        <= '0;
`endif
        end else begin
            err <= 1'b0;
`ifdef DEC_SCAN_EN
            scan_done <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            out_onehot <= sel_onehot;
                            state      <= HOLD;
                        end else begin
                            err <= 1'b1;
                        end
`ifdef DEC_SCAN_EN
                    end else if (scan_req) begin
                        out_onehot <= ONE;
                        idx        <= '0;
                        state      <= SCAN;
`endif
                    end
                end
                HOLD: begin
                    if (zero) begin
                        if (accept && legal) begin
                            // Back-to-back code: switch directly with no idle gap.
                            out_onehot <= sel_onehot;
                        end else begin
                            out_onehot <= '0;
                            err        <= accept;
                            state      <= IDLE;
                        end
                    end
                end
`ifdef DEC_SCAN_EN
                SCAN: begin
                    if (zero) begin
                        if (idx == LAST) begin
                            out_onehot <= '0;
                            scan_done  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            out_onehot <= out_onehot << 1;
                            idx        <= idx + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    out_onehot <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = |out_onehot;
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Directed bench for seq_onehot_decoder.
// dut0 is built with IN_W=3, NUM_OUT=6, HOLD_CYC=3. dut1 is built with HOLD_CYC=1.
module tb_seq_onehot_decoder;
    import dec_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [2:0] in_sel0 = '0, in_sel1 = '0;
    logic       in_ready0, in_ready1;
    logic [5:0] out0, out1;
    logic       out_valid0, out_valid1;
    logic       err0, err1;
    dec_state_e state0, state1;
`ifdef DEC_SCAN_EN
    logic scan_req0 = 1'b0, scan_req1 = 1'b0;
    logic scan_done0, scan_done1;
`endif

    int checks = 0;
    int errors = 0;

    seq_onehot_decoder #(.IN_W(3), .NUM_OUT(6), .HOLD_CYC(3)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_sel(in_sel0),
        .out_onehot(out0), .out_valid(out_valid0), .err(err0),
`ifdef DEC_SCAN_EN
        .scan_req(scan_req0), .scan_done(scan_done0),
`endif
        .dbg_state(state0)
    );

    seq_onehot_decoder #(.IN_W(3), .NUM_OUT(6), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_sel(in_sel1),
        .out_onehot(out1), .out_valid(out_valid1), .err(err1),
`ifdef DEC_SCAN_EN
        .scan_req(scan_req1), .scan_done(scan_done1),
`endif
        .dbg_state(state1)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out0 !== 6'b0) begin errors++; $display("FAIL rst_out: got %b exp 000000", out0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", out_valid0); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", in_ready0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err0); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_rel_ready: got %b exp 1", in_ready0); end
        checks++; if (state0 !== IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", state0, IDLE); end
        // Assert reset asynchronously while a code is being held.
        tick();
        in_valid0 = 1'b1; in_sel0 = 3'd2;
        tick();
        in_valid0 = 1'b0;
        checks++; if (out0 !== 6'b000100) begin errors++; $display("FAIL midhold_out: got %b exp 000100", out0); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (out0 !== 6'b0) begin errors++; $display("FAIL async_out: got %b exp 000000", out0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL async_valid: got %b exp 0", out_valid0); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL async_ready: got %b exp 0", in_ready0); end
        #1 rst = 1'b0;
        #1;
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b exp 1", in_ready0); end
        tick();
        checks++; if (out0 !== 6'b0) begin errors++; $display("FAIL discard_out: got %b exp 000000", out0); end
    endtask

    task automatic test_single_decode();
        logic [5:0] exp_out [4];
        logic       exp_rdy [4];
        exp_out = '{6'b001000, 6'b001000, 6'b001000, 6'b000000};
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        in_valid0 = 1'b1; in_sel0 = 3'd3;
        tick();
        in_valid0 = 1'b0; in_sel0 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out0 !== exp_out[i]) begin errors++; $display("FAIL single_out T+%0d: got %b exp %b", i + 1, out0, exp_out[i]); end
            checks++; if (in_ready0 !== exp_rdy[i]) begin errors++; $display("FAIL single_ready T+%0d: got %b exp %b", i + 1, in_ready0, exp_rdy[i]); end
            checks++; if (out_valid0 !== (exp_out[i] != 6'b0)) begin errors++; $display("FAIL single_valid T+%0d: got %b", i + 1, out_valid0); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_out [7];
        exp_out = '{6'b000010, 6'b000010, 6'b000010, 6'b100000, 6'b100000, 6'b100000, 6'b000000};
        in_valid0 = 1'b1; in_sel0 = 3'd1;
        tick();
        in_sel0 = 3'd5;
        for (int i = 0; i < 7; i++) begin
            checks++; if (out0 !== exp_out[i]) begin errors++; $display("FAIL b2b_out T+%0d: got %b exp %b", i + 1, out0, exp_out[i]); end
            if (i == 2) begin
                checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL b2b_ready T+3: got %b exp 1", in_ready0); end
            end
            tick();
            if (i == 2) in_valid0 = 1'b0;
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] codes [2];
        codes = '{3'd6, 3'd7};
        for (int k = 0; k < 2; k++) begin
            in_valid0 = 1'b1; in_sel0 = codes[k];
            tick();
            in_valid0 = 1'b0;
            checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL oor_err sel=%0d: got %b exp 1", codes[k], err0); end
            checks++; if (out0 !== 6'b0) begin errors++; $display("FAIL oor_out sel=%0d: got %b exp 000000", codes[k], out0); end
            checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL oor_ready sel=%0d: got %b exp 1", codes[k], in_ready0); end
            tick();
            checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL oor_err_clr sel=%0d: got %b exp 0", codes[k], err0); end
        end
        // An illegal code accepted at the end of a hold clears the output and raises err.
        in_valid0 = 1'b1; in_sel0 = 3'd0;
        tick();
        in_sel0 = 3'd7;
        tick();
        tick();
        tick();
        in_valid0 = 1'b0;
        checks++; if (out0 !== 6'b0) begin errors++; $display("FAIL hold_oor_out: got %b exp 000000", out0); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL hold_oor_err: got %b exp 1", err0); end
        tick();
    endtask

    task automatic test_hold_one();
        logic [5:0] exp_out [4];
        exp_out = '{6'b000001, 6'b000010, 6'b000100, 6'b000000};
        in_valid1 = 1'b1; in_sel1 = 3'd0;
        #1;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL h1_ready_start: got %b exp 1", in_ready1); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 2) in_sel1 = 3'(i + 1);
            else in_valid1 = 1'b0;
            checks++; if (out1 !== exp_out[i]) begin errors++; $display("FAIL h1_out step %0d: got %b exp %b", i, out1, exp_out[i]); end
            checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL h1_ready step %0d: got %b exp 1", i, in_ready1); end
        end
    endtask

`ifdef DEC_SCAN_EN
    task automatic test_scan();
        logic [5:0] exp_bit;
        int done_seen;
        done_seen = 0;
        scan_req0 = 1'b1;
        tick();
        scan_req0 = 1'b0;
        exp_bit = 6'b000001;
        for (int i = 0; i < 18; i++) begin
            checks++; if (out0 !== exp_bit) begin errors++; $display("FAIL scan_out cyc %0d: got %b exp %b", i, out0, exp_bit); end
            checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL scan_ready cyc %0d: got %b exp 0", i, in_ready0); end
            if (scan_done0 === 1'b1) done_seen++;
            if ((i % 3) == 2) exp_bit = exp_bit << 1;
            tick();
        end
        checks++; if (out0 !== 6'b0) begin errors++; $display("FAIL scan_end_out: got %b exp 000000", out0); end
        checks++; if (scan_done0 !== 1'b1) begin errors++; $display("FAIL scan_done: got %b exp 1", scan_done0); end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL scan_done_early: got %0d exp 0", done_seen); end
        tick();
        checks++; if (scan_done0 !== 1'b0) begin errors++; $display("FAIL scan_done_clr: got %b exp 0", scan_done0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_decode();
        test_back_to_back();
        test_out_of_range();
        test_hold_one();
`ifdef DEC_SCAN_EN
        test_scan();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
